// File: rtl/program_counter.sv
// Program counter register with a combinational PC+4 output.
// Optional sticky misalignment detector enabled by defining PC_ALIGN_CHECK_EN.
module program_counter #(
  parameter int              N            = 32,
  parameter logic [N-1:0]    RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] Pc_i,
  output logic [N-1:0] Pc_o,
  output logic [N-1:0] Pc_plus4,
  output logic         misaligned
);

  logic [N-1:0] pc_reg;

  // Pc_i is loaded verbatim; alignment is only reported, never enforced.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_VECTOR;
    end else if (en) begin
      pc_reg <= Pc_i;
    end
  end

  assign Pc_o     = pc_reg;
  assign Pc_plus4 = pc_reg + N'(4);

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_reg;

  // Sticky: once a non-word-aligned target is loaded, the flag holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_reg <= 1'b0;
    end else if (en && (Pc_i[1:0] != 2'b00)) begin
      misaligned_reg <= 1'b1;
    end
  end

  assign misaligned = misaligned_reg;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (N=32, RESET_VECTOR=0).
// Expected misaligned values follow whether PC_ALIGN_CHECK_EN is defined.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] Pc_i;
  logic [31:0] Pc_o;
  logic [31:0] Pc_plus4;
  logic        misaligned;

  int pass_count  = 0;
  int check_count = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic MIS_ON = 1'b1;
`else
  localparam logic MIS_ON = 1'b0;
`endif

  program_counter #(
    .N            (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .Pc_i       (Pc_i),
    .Pc_o       (Pc_o),
    .Pc_plus4   (Pc_plus4),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) begin
      pass_count++;
      $display("check %-16s observed=%08h expected=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check_count++;
    assert (obs === exp) begin
      pass_count++;
      $display("check %-16s observed=%0b expected=%0b ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [31:0] d);
    reset = r;
    en    = e;
    Pc_i  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    Pc_i  = '0;
    #2;

    // Reset wins over a simultaneous load.
    step(1'b1, 1'b1, 32'h0000_5A5C);
    check32("rst_pc", Pc_o, 32'h0000_0000);
    check32("rst_plus4", Pc_plus4, 32'h0000_0004);
    check1("rst_mis", misaligned, 1'b0);

    // Consecutive loads, one-cycle latency.
    step(1'b0, 1'b1, 32'h0000_5A5C);
    check32("load0_pc", Pc_o, 32'h0000_5A5C);
    check32("load0_plus4", Pc_plus4, 32'h0000_5A60);
    step(1'b0, 1'b1, 32'h0000_5A60);
    check32("load1_pc", Pc_o, 32'h0000_5A60);
    check32("load1_plus4", Pc_plus4, 32'h0000_5A64);
    step(1'b0, 1'b1, 32'h0000_5A64);
    check32("load2_pc", Pc_o, 32'h0000_5A64);
    check32("load2_plus4", Pc_plus4, 32'h0000_5A68);
    check1("aligned_mis", misaligned, 1'b0);

    // Stall for three edges, then resume.
    step(1'b0, 1'b1, 32'h0000_5A60);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0000_1234);
      check32($sformatf("stall%0d_pc", i), Pc_o, 32'h0000_5A60);
    end
    step(1'b0, 1'b1, 32'h0000_1234);
    check32("resume_pc", Pc_o, 32'h0000_1234);

    // Input changes between edges must not reach Pc_o.
    step(1'b0, 1'b1, 32'h0000_5A64);
    Pc_i = 32'h0000_7770;
    #2;
    check32("midcyc_pi_pc", Pc_o, 32'h0000_5A64);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    check32("rst_pulse_pc", Pc_o, 32'h0000_5A64);

    // Reset held through an edge discards the current PC.
    step(1'b1, 1'b1, 32'h000A_BCD0);
    check32("rst_mid_pc", Pc_o, 32'h0000_0000);
    check32("rst_mid_plus4", Pc_plus4, 32'h0000_0004);
    step(1'b0, 1'b0, 32'h000A_BCD0);
    check32("rst_hold_pc", Pc_o, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h000A_BCD0);
    check32("post_rst_pc", Pc_o, 32'h000A_BCD0);

    // Wrap of the +4 adder.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    check32("wrap_pc", Pc_o, 32'hFFFF_FFFC);
    check32("wrap_plus4", Pc_plus4, 32'h0000_0000);

    // Misaligned target while stalled must not set the flag.
    step(1'b0, 1'b0, 32'h0000_0003);
    check1("stall_mis", misaligned, 1'b0);

    // Alignment checker: flag sets, sticks, clears on reset.
    step(1'b0, 1'b1, 32'h0000_5A5E);
    check32("mis_load_pc", Pc_o, 32'h0000_5A5E);
    check32("mis_plus4", Pc_plus4, 32'h0000_5A62);
    check1("mis_set", misaligned, MIS_ON);
    step(1'b0, 1'b1, 32'h0000_5A60);
    check32("mis_next_pc", Pc_o, 32'h0000_5A60);
    check1("mis_sticky", misaligned, MIS_ON);
    step(1'b0, 1'b0, 32'h0000_0000);
    check1("mis_stall_hold", misaligned, MIS_ON);
    step(1'b1, 1'b0, 32'h0000_0000);
    check1("mis_cleared", misaligned, 1'b0);
    check32("mis_rst_pc", Pc_o, 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
